data_sram_arbiter: RTL and testbench

//   Shares the single data SRAM port between two requesters: the CPU memory stage
//   (port 0) and a DMA/debug master (port 1).

---
 rtl/cpu_defs.sv | 25 ++
 rtl/data_sram_arbiter.sv | 109 ++++++++++
 tb/tb_data_sram_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared constants and payload type for the data SRAM arbiter.
package cpu_defs;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WEN_W  = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [WEN_W-1:0] WEN_READ = 4'b0000;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  // One SRAM access as presented by a requester
  typedef struct packed {
    logic [WEN_W-1:0]  wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/data_sram_arbiter.sv
// Two-port arbiter for the data SRAM: CPU has priority, DMA is force-granted
// after STARVE_LIMIT consecutive lost cycles. Read data is steered back by tag.
module data_sram_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic [WEN_W-1:0]  m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [WEN_W-1:0]  m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              data_sram_en,
  output logic [WEN_W-1:0]  data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic [DATA_W-1:0] data_sram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             rd_tag_v;
  logic             rd_tag;
  sram_req_t        sel;

  // Same-cycle grant; priority flips to the DMA port while forcing
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (resetn) begin
      if (state == ARB_FORCE) begin
        if (m1_req)      m1_gnt = 1'b1;
        else if (m0_req) m0_gnt = 1'b1;
      end else begin
        if (m0_req)      m0_gnt = 1'b1;
        else if (m1_req) m1_gnt = 1'b1;
      end
    end
  end

  // SRAM request mux; idle bus is all zeros
  always_comb begin
    sel = '0;
    if (m0_gnt)      sel = '{wen: m0_wen, addr: m0_addr, wdata: m0_wdata};
    else if (m1_gnt) sel = '{wen: m1_wen, addr: m1_addr, wdata: m1_wdata};
  end

  assign data_sram_en    = m0_gnt | m1_gnt;
  assign data_sram_wen   = sel.wen;
  assign data_sram_addr  = sel.addr;
  assign data_sram_wdata = sel.wdata;

  // Next starvation count: grows while DMA is denied, saturating at the limit
  always_comb begin
    wait_nxt = '0;
    if (m1_req && !m1_gnt) begin
      wait_nxt = (wait_cnt >= LIMIT_C) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  // Starvation counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wait_cnt <= '0;
    else         wait_cnt <= wait_nxt;
  end

  // Arbitration mode: force for one DMA grant once the limit is reached
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ARB_NORMAL;
    end else begin
      case (state)
        ARB_NORMAL: if (wait_nxt == LIMIT_C)  state <= ARB_FORCE;
        ARB_FORCE:  if (m1_gnt || !m1_req)    state <= ARB_NORMAL;
        default:                              state <= ARB_NORMAL;
      endcase
    end
  end

  // Read tag: remembers which port owns the data returning next cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_tag_v <= 1'b0;
      rd_tag   <= PORT_CPU;
    end else begin
      rd_tag_v <= data_sram_en && (data_sram_wen == WEN_READ);
      rd_tag   <= m1_gnt ? PORT_DMA : PORT_CPU;
    end
  end

  assign m0_rvalid = rd_tag_v & ~rd_tag;
  assign m1_rvalid = rd_tag_v & rd_tag;
  assign rdata     = data_sram_rdata;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Randomized self-checking bench for data_sram_arbiter with a small SRAM model.
module tb_data_sram_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m1_req;
  logic [3:0]  m0_wen, m1_wen;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  data_sram_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM behaviour driven by the DUT bus: 1-cycle read latency, byte writes
  logic [31:0] sram_mem [16];
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_wen == 4'b0000) data_sram_rdata <= sram_mem[data_sram_addr[5:2]];
      else
        for (int b = 0; b < 4; b++)
          if (data_sram_wen[b]) sram_mem[data_sram_addr[5:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  end

  // Reference: memory contents, outstanding read and DMA losing streak
  logic [31:0] ref_mem [16];
  logic        pend_v;
  logic        pend_port;
  logic [31:0] pend_data;
  int          streak;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check against the reference, then advance it
  task automatic step(input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
                      output logic g0, output logic g1);
    logic [3:0]  ew;
    logic [31:0] ea, ed;
    @(negedge clk);
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
    #1;
    g1 = r1 && (streak >= LIMIT || !r0);
    g0 = r0 && !g1;
    ew = g0 ? w0 : (g1 ? w1 : 4'h0);
    ea = g0 ? a0 : (g1 ? a1 : 32'h0);
    ed = g0 ? d0 : (g1 ? d1 : 32'h0);
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("sram_en", 32'(data_sram_en), 32'(g0 || g1));
    chk("sram_wen", 32'(data_sram_wen), 32'(ew));
    chk("sram_addr", data_sram_addr, ea);
    chk("sram_wdata", data_sram_wdata, ed);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(pend_v && !pend_port));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(pend_v && pend_port));
    if (pend_v) chk("rdata", rdata, pend_data);
    pend_v    = (g0 || g1) && ew == 4'h0;
    pend_port = g1;
    pend_data = ref_mem[ea[5:2]];
    if ((g0 || g1) && ew != 4'h0)
      for (int b = 0; b < 4; b++)
        if (ew[b]) ref_mem[ea[5:2]][8*b +: 8] = ed[8*b +: 8];
    if (r1 && !g1) streak++;
    else           streak = 0;
  endtask

  function automatic logic [3:0] rand_wen();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0, g1;
    logic        h0_r, h1_r;
    logic [3:0]  h0_w, h1_w;
    logic [31:0] h0_a, h0_d, h1_a, h1_d;
    logic [31:0] v;

    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[0] = 32'hDEADBEEF;
    ref_mem[0]  = 32'hDEADBEEF;
    pend_v = 1'b0; pend_port = 1'b0; pend_data = '0; streak = 0;

    // Reset with both ports requesting: nothing may be granted
    resetn = 1'b0;
    m0_req = 1'b1; m0_wen = 4'h0; m0_addr = 32'h40; m0_wdata = '0;
    m1_req = 1'b1; m1_wen = 4'h0; m1_addr = 32'h44; m1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("rst_en", 32'(data_sram_en), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); resetn = 1'b1;

    // Solo CPU read of the preloaded word
    step(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);
    chk("t2_addr", data_sram_addr, 32'h100);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);
    chk("t2_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    chk("t2_m1_rvalid", 32'(m1_rvalid), 32'h0);

    // Starvation with reads on both ports: 8 CPU grants, then one DMA grant
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b1, 4'h0, 32'h3C, 32'h0, g0, g1);
      if (i < 8)       chk("t3_m0_gnt", 32'(m0_gnt), 32'h1);
      else if (i == 8) chk("t3_m1_gnt", 32'(m1_gnt), 32'h1);
      else             chk("t3_m0_again", 32'(m0_gnt), 32'h1);
      if (i == 8) chk("t5_m0_rvalid", 32'(m0_rvalid), 32'h1);
      if (i == 9) chk("t5_m1_rvalid", 32'(m1_rvalid), 32'h1);
      if (i == 9) chk("t5_rdata", rdata, ref_mem[15]);
    end

    // DMA store: no read return afterwards
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h20, 32'h0000ABCD, g0, g1);
    chk("t4_wen", 32'(data_sram_wen), 32'h3);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);
    chk("t4_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0, g0, g1);

    // Reset the cycle after a granted DMA read: its return must be dropped
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0, g0, g1);
    @(negedge clk);
    resetn = 1'b0; #1;
    chk("t6_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("t6_en", 32'(data_sram_en), 32'h0);
    pend_v = 1'b0; streak = 0;
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);
    step(1'b1, 4'h0, 32'h4, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0, g0, g1);
    chk("t6_normal", 32'(m0_gnt), 32'h1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0, g0, g1);

    // Random traffic; a denied requester holds its request and payload
    h0_r = 1'b0; h1_r = 1'b0;
    h0_w = '0; h1_w = '0; h0_a = '0; h1_a = '0; h0_d = '0; h1_d = '0;
    for (int n = 0; n < 3000; n++) begin
      step(h0_r, h0_w, h0_a, h0_d, h1_r, h1_w, h1_a, h1_d, g0, g1);
      if (!h0_r || g0) begin
        h0_r = ($urandom_range(0, 9) < 7);
        h0_w = rand_wen(); h0_a = $urandom; h0_d = $urandom;
      end
      if (!h1_r || g1) begin
        h1_r = ($urandom_range(0, 9) < 6);
        h1_w = rand_wen(); h1_a = $urandom; h1_d = $urandom;
      end
    end
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, g0, g1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
